// File: rtl/mem_access_if.sv
// Request/response and RAM-side signal bundle for mem_access_unit.
// The unit attaches through the slave modport; the datapath/RAM side uses master.
interface mem_access_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word access to a word-addressed RAM with sign/zero extension
// and read-modify-write for SB/SH. Define MAU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_unit #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] ERR_RDATA = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_word;
    logic              illegal;
    logic              misaligned;
    logic              start_access;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [31:0]       merged;
    logic              unused_addr_bits;

    // Address bits above the RAM range are dropped so accesses wrap.
    assign req_word         = bus.req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2]};

    always_comb begin
        illegal = 1'b1;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.req_write;
            default:                illegal = 1'b1;
        endcase
`ifdef MAU_MISALIGN_TRAP_EN
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    assign start_access = (state_q == IDLE) && bus.req_valid && !illegal && !misaligned;

    // Lane extraction and store merge both use the latched low address bits.
    always_comb begin
        ld_byte = bus.mem_q[{lane_q, 3'b000} +: 8];
        ld_half = bus.mem_q[{lane_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.mem_q;
        endcase
        merged = bus.mem_q;
        if (funct3_q == 3'b000) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lane_d   = lane_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = req_word;
                    lane_d   = bus.req_addr[1:0];
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = 1'b0;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                        state_d = RESP;
                    end else if (!bus.req_write) begin
                        state_d = LD_WAIT;
                    end else if (bus.req_funct3 == 3'b010) begin
                        state_d = RMW_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_WAIT: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            RMW_RD: begin
                wdata_d = merged;
                state_d = RMW_WR;
            end
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lane_q   <= lane_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // The RAM address is presented on the accept cycle so read data arrives in the next state.
    assign bus.mem_addr   = start_access ? req_word : addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wren   = (state_q == RMW_WR);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a synchronous-read RAM model.
// Expected values are hand-computed; misalignment expectations follow MAU_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] ram [0:255];

    int          lat;
    int          wren_cnt;
    int          busy_cnt;
    logic [31:0] got_rdata;
    logic        got_err;
    int          pulse_cnt;

    mem_access_if #(.ADDR_W(8)) bus ();

    mem_access_unit #(.ADDR_W(8), .ERR_RDATA(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write and read both happen at posedge, read returns the old word.
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request at a negedge and follows it until resp_valid, recording latency and activity.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0BAD_0BAD;
        lat = -1; wren_cnt = 0; busy_cnt = 0;
        got_rdata = 32'hXXXX_XXXX; got_err = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            if (!bus.req_ready) busy_cnt++;
            if (bus.mem_wren) wren_cnt++;
            if (bus.resp_valid) begin
                lat = i;
                got_rdata = bus.resp_rdata;
                got_err = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput("resp_pulse_drops", {31'h0, bus.resp_valid}, 32'h0);
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[1] = 32'h80FF_7F01;
        ram[2] = 32'h1122_3344;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        checkOutput("rst_mem_wren", {31'h0, bus.mem_wren}, 32'h0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        checkOutput("rst_mem_addr", {24'h0, bus.mem_addr}, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_wren) pulse_cnt++;
        end
        checkOutput("idle_no_pulses", pulse_cnt, 0);
        checkOutput("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);

        applyStimulus(1'b0, 3'b000, 32'h7, 32'h0);
        checkOutput("lb_data", got_rdata, 32'hFFFF_FF80);
        checkOutput("lb_lat", lat, 2);
        checkOutput("lb_err", {31'h0, got_err}, 32'h0);

        applyStimulus(1'b0, 3'b100, 32'h7, 32'h0);
        checkOutput("lbu_data", got_rdata, 32'h0000_0080);
        checkOutput("lbu_lat", lat, 2);

        applyStimulus(1'b0, 3'b001, 32'h6, 32'h0);
        checkOutput("lh_data", got_rdata, 32'hFFFF_80FF);
        checkOutput("lh_lat", lat, 2);

        applyStimulus(1'b0, 3'b101, 32'h6, 32'h0);
        checkOutput("lhu_data", got_rdata, 32'h0000_80FF);

        applyStimulus(1'b0, 3'b000, 32'h4, 32'h0);
        checkOutput("lb_lane0_pos", got_rdata, 32'h0000_0001);

        applyStimulus(1'b1, 3'b000, 32'h9, 32'h1234_56AA);
        checkOutput("sb_ram", ram[2], 32'h1122_AA44);
        checkOutput("sb_wren_cycles", wren_cnt, 1);
        checkOutput("sb_lat", lat, 3);
        checkOutput("sb_busy", busy_cnt, 3);
        checkOutput("sb_rdata_zero", got_rdata, 32'h0);

        applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
        checkOutput("sw_lat", lat, 2);
        checkOutput("sw_wren_cycles", wren_cnt, 1);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0);
        checkOutput("lw_after_sw", got_rdata, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 3'b001, 32'hA, 32'h0000_5A5A);
        checkOutput("sh_ram", ram[2], 32'h5A5A_BEEF);
        checkOutput("sh_lat", lat, 3);

        applyStimulus(1'b0, 3'b010, 32'h5, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
        checkOutput("lw_misaligned_err", {31'h0, got_err}, 32'h1);
        checkOutput("lw_misaligned_data", got_rdata, 32'h0);
        checkOutput("lw_misaligned_lat", lat, 1);
`else
        checkOutput("lw_misaligned_err", {31'h0, got_err}, 32'h0);
        checkOutput("lw_misaligned_data", got_rdata, 32'h80FF_7F01);
        checkOutput("lw_misaligned_lat", lat, 2);
`endif

        applyStimulus(1'b0, 3'b011, 32'h4, 32'h0);
        checkOutput("illegal_err", {31'h0, got_err}, 32'h1);
        checkOutput("illegal_lat", lat, 1);
        checkOutput("illegal_data", got_rdata, 32'h0);

        applyStimulus(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);
        checkOutput("store_bu_err", {31'h0, got_err}, 32'h1);
        checkOutput("store_bu_no_wren", wren_cnt, 0);
        checkOutput("store_bu_ram", ram[2], 32'h5A5A_BEEF);

        // Reset lands while the SB is in its read phase.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("mid_pre_busy", {31'h0, bus.req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("mid_rst_wren", {31'h0, bus.mem_wren}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_wren) pulse_cnt++;
        end
        checkOutput("mid_rst_no_pulses", pulse_cnt, 0);
        checkOutput("mid_rst_ram", ram[1], 32'h80FF_7F01);

        applyStimulus(1'b0, 3'b010, 32'h404, 32'h0);
        checkOutput("wrap_lw_data", got_rdata, 32'h80FF_7F01);
        checkOutput("wrap_lw_err", {31'h0, got_err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
